// File: rtl/branch_pkg.sv
// Shared encodings for the branch sequencing controller: funct3 branch ops,
// controller state codes and the op legality check.
package branch_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EVAL  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // funct3 values 010 and 011 have no conditional-branch meaning in RV32I
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != 3'b010) && (op != 3'b011);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/branch_ctrl.sv
// Sequences one conditional branch through the shared branch_unit: latch,
// evaluate, then redirect fetch and hold a flush when the branch is taken.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_branch_op,
    input  logic [DATA_WIDTH-1:0] i_rs1,
    input  logic [DATA_WIDTH-1:0] i_rs2,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_imm,
    output logic                  o_bu_branch,
    output logic [2:0]            o_bu_op,
    output logic [DATA_WIDTH-1:0] o_bu_a,
    output logic [DATA_WIDTH-1:0] o_bu_b,
    input  logic                  i_bu_take,
    output logic                  o_redirect,
    output logic [DATA_WIDTH-1:0] o_target,
    output logic                  o_flush,
    output logic                  o_illegal,
    output logic                  o_misaligned,
    output logic [CNT_WIDTH-1:0]  o_branch_cnt,
    output logic [CNT_WIDTH-1:0]  o_taken_cnt
);

    logic [1:0]            state_q, state_d;
    logic [3:0]            flush_cnt_q, flush_cnt_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
    logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic                  redirect_q, redirect_d;
    logic [DATA_WIDTH-1:0] target_q, target_d;
    logic                  illegal_q, illegal_d;
    logic                  misaligned_q, misaligned_d;

    logic                  transfer;
    logic                  op_legal;
    logic                  in_eval;
    logic [DATA_WIDTH-1:0] target_calc;
    logic                  target_aligned;
    logic                  take_aligned;
    logic                  take_misaligned;

    assign transfer        = i_valid && (state_q == ST_IDLE);
    assign op_legal        = is_legal_op(i_branch_op);
    assign in_eval         = (state_q == ST_EVAL);
    assign target_calc     = pc_q + imm_q;
    assign target_aligned  = (target_calc[1:0] == 2'b00);
    assign take_aligned    = in_eval && i_bu_take && target_aligned;
    assign take_misaligned = in_eval && i_bu_take && !target_aligned;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            flush_cnt_q  <= '0;
            op_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            pc_q         <= '0;
            imm_q        <= '0;
            redirect_q   <= 1'b0;
            target_q     <= '0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            pc_q         <= pc_d;
            imm_q        <= imm_d;
            redirect_q   <= redirect_d;
            target_q     <= target_d;
            illegal_q    <= illegal_d;
            misaligned_q <= misaligned_d;
        end
    end

    // The flush counter is loaded on the redirect edge and leaves FLUSH at 1,
    // giving exactly FLUSH_CYCLES flush cycles.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer && op_legal) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (take_aligned) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = 4'(FLUSH_CYCLES);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        op_d         = op_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        target_d     = target_q;
        redirect_d   = take_aligned;
        misaligned_d = take_misaligned;
        illegal_d    = transfer && !op_legal;
        if (transfer && op_legal) begin
            op_d  = i_branch_op;
            rs1_d = i_rs1;
            rs2_d = i_rs2;
            pc_d  = i_pc;
            imm_d = i_imm;
        end
        if (take_aligned) begin
            target_d = target_calc;
        end
    end

    always_comb begin
        o_ready      = (state_q == ST_IDLE);
        o_bu_branch  = (state_q == ST_EVAL);
        o_flush      = (state_q == ST_FLUSH);
        o_bu_op      = op_q;
        o_bu_a       = rs1_q;
        o_bu_b       = rs2_q;
        o_redirect   = redirect_q;
        o_target     = target_q;
        o_illegal    = illegal_q;
        o_misaligned = misaligned_q;
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_branch_cnt (
        .i_clk  (i_clk),
        .i_clr  (i_rst),
        .i_inc  (in_eval),
        .o_count(o_branch_cnt)
    );

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_taken_cnt (
        .i_clk  (i_clk),
        .i_clr  (i_rst),
        .i_inc  (take_aligned),
        .o_count(o_taken_cnt)
    );

endmodule
